// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the boot-time IMEM loader.
// IMEM_DEPTH_DEF is also the default depth of the instruction memory itself.
package imem_loader_pkg;
  localparam int IMEM_DEPTH_DEF  = 1024;
  localparam int HDR_BYTES       = 4;
  localparam int BYTES_PER_WORD  = 4;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_DATA,
    ST_FLUSH,
    ST_DONE,
    ST_ERR
  } ld_state_e;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 8-to-32 assembler. o_word already includes the byte being
// accepted this cycle, so the caller can act on a full word at that edge.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);
  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_word;
  logic [31:0]      w_word;

  always_comb begin
    w_word = r_word;
    w_word[{r_idx, 3'b000} +: 8] = i_byte;
  end

  assign o_word      = w_word;
  assign o_word_full = i_en && (r_idx == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clr) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_en) begin
      r_word <= w_word;
      r_idx  <= r_idx + 1'b1;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Boot loader: header word count, then N little-endian words written to IMEM
// at consecutive addresses; holds the core in reset until the image is in.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = IMEM_DEPTH_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        start,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  ld_state_e   r_state;
  logic [31:0] r_n;
  logic [31:0] r_wcnt;
  logic        r_we;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;
  logic        r_cpu_rst;
  logic        r_done;
  logic        r_err;

  logic        w_accept;
  logic        w_reload;
  logic        w_full;
  logic        w_last;
  logic [31:0] w_word;

  assign rx_ready = (r_state == ST_HDR) || (r_state == ST_DATA);
  assign w_accept = rx_valid && rx_ready;
  assign w_reload = start && ((r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_last   = (r_wcnt + 32'd1) == r_n;

  // Header and data bytes share one packer; the header is just a word.
  imem_loader_byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_reload),
    .i_en        (w_accept),
    .i_byte      (rx_data),
    .o_word      (w_word),
    .o_word_full (w_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_HDR;
      r_n       <= '0;
      r_wcnt    <= '0;
      r_we      <= 1'b0;
      r_waddr   <= BASE_ADDR;
      r_wdata   <= '0;
      r_cpu_rst <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      // Address steps after each pulse so waddr matches wdata during we.
      if (r_we) r_waddr <= r_waddr + 32'd4;
      case (r_state)
        ST_HDR: if (w_full) begin
          r_n <= w_word;
          if (w_word == 32'd0) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b1;
          end else if (w_word > DEPTH_W) begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
          end else begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: if (w_full) begin
          r_we    <= 1'b1;
          r_wdata <= w_word;
          r_wcnt  <= r_wcnt + 32'd1;
          if (w_last) r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          r_state   <= ST_DONE;
          r_done    <= 1'b1;
          r_cpu_rst <= 1'b1;
        end
        ST_DONE, ST_ERR: if (start) begin
          r_state   <= ST_HDR;
          r_done    <= 1'b0;
          r_err     <= 1'b0;
          r_cpu_rst <= 1'b0;
          r_n       <= '0;
          r_wcnt    <= '0;
          r_waddr   <= BASE_ADDR;
        end
        default: r_state <= ST_HDR;
      endcase
    end
  end

  assign we      = r_we;
  assign waddr   = r_waddr;
  assign wdata   = r_wdata;
  assign cpu_rst = r_cpu_rst;
  assign done    = r_done;
  assign err     = r_err;
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader; the write side of the instruction memory.
- Consumes a byte stream (e.g. from a UART receiver), assembles little-endian 32-bit instruction words, and drives an IMEM write port at consecutive word addresses.
- Holds the CPU core in reset until the image is fully written, then releases it.

Parameters:
- DEPTH, 1024, IMEM depth in words; the word-count limit.
- BASE_ADDR, 32'h00000000, byte address of the first written word; must be word aligned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx_valid  input  1  byte available on rx_data.
- rx_data  input  8  stream byte.
- rx_ready  output  1  loader accepts a byte this cycle.
- start  input  1  single-cycle pulse that requests a reload; honoured only in DONE or ERR.
- we  output  1  IMEM write enable, one-cycle pulse per word.
- waddr  output  32  IMEM byte address, word aligned.
- wdata  output  32  assembled instruction word.
- cpu_rst  output  1  active-low reset to the core; 0 while loading.
- done  output  1  image loaded, core released.
- err  output  1  header word count exceeds DEPTH.

Behaviour:
- Reset (rst=0, async):
  - State goes to HDR; byte and word counters clear.
  - Outputs: we=0, waddr=BASE_ADDR, wdata=0, cpu_rst=0, done=0, err=0. rx_ready=1 once reset releases.
- Transfer rule: a byte is accepted on a rising edge where rx_valid&rx_ready. rx_data is ignored otherwise. Bubbles on rx_valid are legal and only stall progress.
- Stream format:
  - 4 header bytes give word count N, least significant byte first.
  - Then N*4 data bytes. Within each word, byte 0 goes to wdata[7:0] and byte 3 to wdata[31:24].
- HDR (rx_ready=1):
  - Collect 4 bytes into N.
  - On the 4th byte: N==0 -> DONE; N>DEPTH -> ERR; otherwise -> DATA.
- DATA (rx_ready=1):
  - A 2-bit byte index selects the byte lane.
  - When the 4th byte of a word is accepted, we=1 in the following cycle, carrying that word on wdata and its address on waddr.
  - waddr advances by 4 after each pulse. Address arithmetic is 32-bit; no overflow is possible because N<=DEPTH.
  - rx_ready stays 1 during the we cycle of a non-final word.
  - The 4th byte of the final word moves the state to FLUSH.
- FLUSH (rx_ready=0): the final we pulse occurs in this cycle; next state is DONE.
- DONE:
  - done=1 and cpu_rst=1 from the cycle after the final we pulse (immediately after the header when N==0).
  - rx_ready=0; extra stream bytes are not consumed.
- ERR: err=1, rx_ready=0, cpu_rst=0, and no write ever occurs for that image.
- start:
  - In DONE or ERR, start moves the state to HDR on the next edge. At that edge: done=0, err=0, cpu_rst=0, counters cleared, waddr=BASE_ADDR.
  - start is ignored in HDR, DATA and FLUSH.
- Reset mid-load: async reset aborts immediately. Partial IMEM contents are don't-care; the next stream is treated as a new header.
- Registered outputs: we, waddr, wdata, cpu_rst, done and err are all registered. rx_ready is a decode of the state only, with no combinational path from rx_valid.

Decomposition:
- Shared package/header holds:
  - the state encoding (HDR, DATA, FLUSH, DONE, ERR);
  - HDR_BYTES=4 and BYTES_PER_WORD=4;
  - the default IMEM depth constant, shared with the instruction memory.
- Natural sub-module: byte_packer. It handles 8-to-32 little-endian shift/lane assembly and the byte index, and reports word_full. FSM and counters stay in the top level.

Test Plan:
1. Stream 02 00 00 00, 13 00 50 00, 93 00 10 00 -> we at waddr 0x0 with wdata 0x00500013, then at 0x4 with 0x00100093. done=1 and cpu_rst=1 one cycle after the second pulse.
2. Header 00 00 00 00 -> no we; done=1 and cpu_rst=1 the cycle after the 4th byte.
3. Header 01 04 00 00 (N=1025) -> err=1, rx_ready=0, no we, cpu_rst stays 0 for 50 cycles.
4. Case 1 with random 0-5 cycle rx_valid gaps -> identical write sequence and addresses.
5. Assert rst after 6 bytes of case 1, release, send case 1 again -> clean reload: first we at 0x0 with 0x00500013, done asserted.
6. After case 1 completes, pulse start, then send 01 00 00 00, EF BE AD DE -> cpu_rst falls the cycle after start; we at 0x0 with 0xDEADBEEF; done returns to 1.
